mgt_01_div_sequencer: RTL and testbench

//  Issue/completion sequencer directly upstream of MGT_01_div_unit.
//  - Accepts one M-extension divide op (DIV/DIVU/REM/REMU) per handshake.
//  - Holds the operands stable and gates the divider's clk_en_i.
//  - Resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
//  - Returns the tagged result to writeback over a valid/ready handshake.

---
 rtl/mgt_01_div_sequencer_pkg.sv | 38 +++
 rtl/mgt_01_div_sequencer_if.sv | 50 +++++
 rtl/mgt_01_div_special_case.sv | 28 ++
 rtl/mgt_01_div_sequencer.sv | 152 +++++++++++++++
 tb/tb_mgt_01_div_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mgt_01_div_sequencer_pkg.sv
// rtl/mgt_01_div_sequencer_pkg.sv - shared types and constants for the divide sequencer
package MGT_01_pkg;

    localparam int XLEN        = 32;
    localparam int TAG_W       = 4;
    localparam int RD_W        = 5;
    localparam int DIV_LATENCY = 34;

    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SPECIAL = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    function automatic logic is_signed_op(input div_ops_e op);
        return (op == DIV_) || (op == REM_);
    endfunction

    function automatic logic is_quotient_op(input div_ops_e op);
        return (op == DIV_) || (op == DIVU_);
    endfunction

endpackage

// File: rtl/mgt_01_div_sequencer_if.sv
// rtl/mgt_01_div_sequencer_if.sv - issue, divider and writeback signal bundle
interface mgt_01_div_sequencer_if;
    import MGT_01_pkg::*;

    // issue side
    logic             issue_valid_i;
    logic             issue_ready_o;
    div_ops_e         issue_op_i;
    logic [XLEN-1:0]  issue_rs1_i;
    logic [XLEN-1:0]  issue_rs2_i;
    logic [TAG_W-1:0] issue_tag_i;
    logic [RD_W-1:0]  issue_rd_i;

    // divider side
    logic [XLEN-1:0]  div_dividend_o;
    logic [XLEN-1:0]  div_divisor_o;
    div_ops_e         div_op_o;
    logic             div_clk_en_o;
    logic [XLEN-1:0]  div_result_i;
    fu_state_e        div_state_i;

    // writeback side
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [XLEN-1:0]  wb_result_o;
    logic [TAG_W-1:0] wb_tag_o;
    logic [RD_W-1:0]  wb_rd_o;
    logic             wb_dz_o;

    // the sequencer itself
    modport slave (
        input  issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_tag_i, issue_rd_i,
        output issue_ready_o,
        output div_dividend_o, div_divisor_o, div_op_o, div_clk_en_o,
        input  div_result_i, div_state_i,
        output wb_valid_o, wb_result_o, wb_tag_o, wb_rd_o, wb_dz_o,
        input  wb_ready_i
    );

    // the pipeline, divider and writeback around it
    modport master (
        output issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_tag_i, issue_rd_i,
        input  issue_ready_o,
        input  div_dividend_o, div_divisor_o, div_op_o, div_clk_en_o,
        output div_result_i, div_state_i,
        input  wb_valid_o, wb_result_o, wb_tag_o, wb_rd_o, wb_dz_o,
        output wb_ready_i
    );

endinterface

// File: rtl/mgt_01_div_special_case.sv
// rtl/mgt_01_div_special_case.sv - detect divide-by-zero / signed overflow and form their result
module mgt_01_div_special_case
    import MGT_01_pkg::*;
(
    input  div_ops_e        i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_special,
    output logic [XLEN-1:0] o_result,
    output logic            o_dz
);

    // RISC-V defines both cases without a trap, so they never need the divider
    always_comb begin
        o_special = 1'b0;
        o_result  = '0;
        o_dz      = 1'b0;
        if (i_rs2 == '0) begin
            o_special = 1'b1;
            o_dz      = 1'b1;
            o_result  = is_quotient_op(i_op) ? '1 : i_rs1;
        end else if (is_signed_op(i_op) && (i_rs1 == INT_MIN) && (i_rs2 == '1)) begin
            o_special = 1'b1;
            o_result  = is_quotient_op(i_op) ? i_rs1 : '0;
        end
    end

endmodule

// File: rtl/mgt_01_div_sequencer.sv
// rtl/mgt_01_div_sequencer.sv - issue/completion sequencer in front of the iterative divider
module mgt_01_div_sequencer
    import MGT_01_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    mgt_01_div_sequencer_if.slave bus
);

    localparam int               CNT_W    = $clog2(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;

    div_ops_e         r_op;
    logic [XLEN-1:0]  r_rs1;
    logic [XLEN-1:0]  r_rs2;
    logic [TAG_W-1:0] r_tag;
    logic [RD_W-1:0]  r_rd;
    logic [XLEN-1:0]  r_result;
    logic             r_dz;

    logic             w_accept;
    logic             w_capture;
    logic             w_issue_ready;
    logic             w_clk_en;
    logic             w_wb_valid;

    logic             w_special;
    logic [XLEN-1:0]  w_special_result;
    logic             w_special_dz;

    // classification runs on the incoming operands so the branch is known at accept
    mgt_01_div_special_case u_special (
        .i_op      (bus.issue_op_i),
        .i_rs1     (bus.issue_rs1_i),
        .i_rs2     (bus.issue_rs2_i),
        .o_special (w_special),
        .o_result  (w_special_result),
        .o_dz      (w_special_dz)
    );

    // state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and handshake outputs; flush overrides everything
    always_comb begin
        w_next        = r_state;
        w_issue_ready = 1'b0;
        w_clk_en      = 1'b0;
        w_wb_valid    = 1'b0;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                w_issue_ready = 1'b1;
                if (bus.issue_valid_i) begin
                    w_accept = 1'b1;
                    w_next   = w_special ? SPECIAL : RUN;
                end
            end
            RUN: begin
                w_clk_en = 1'b1;
                if ((r_cnt == CNT_LAST) && (bus.div_state_i == FREE)) begin
                    w_capture = 1'b1;
                    w_next    = DONE;
                end
            end
            SPECIAL: begin
                w_next = DONE;
            end
            DONE: begin
                w_wb_valid    = 1'b1;
                w_issue_ready = bus.wb_ready_i;
                if (bus.wb_ready_i) begin
                    if (bus.issue_valid_i) begin
                        w_accept = 1'b1;
                        w_next   = w_special ? SPECIAL : RUN;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush_i) begin
            w_next        = IDLE;
            w_issue_ready = 1'b0;
            w_clk_en      = 1'b0;
            w_wb_valid    = 1'b0;
            w_accept      = 1'b0;
            w_capture     = 1'b0;
        end
    end

    // latency counter, saturating at the sample point while the divider is still busy
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == RUN) && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // payload: operands latched on accept, result from special path or divider
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_op     <= DIV_;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_tag    <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_dz     <= 1'b0;
        end else if (w_accept) begin
            r_op  <= bus.issue_op_i;
            r_rs1 <= bus.issue_rs1_i;
            r_rs2 <= bus.issue_rs2_i;
            r_tag <= bus.issue_tag_i;
            r_rd  <= bus.issue_rd_i;
            r_dz  <= w_special_dz;
            if (w_special) begin
                r_result <= w_special_result;
            end
        end else if (w_capture) begin
            r_result <= bus.div_result_i;
        end
    end

    assign bus.issue_ready_o  = w_issue_ready;
    assign bus.div_dividend_o = r_rs1;
    assign bus.div_divisor_o  = r_rs2;
    assign bus.div_op_o       = r_op;
    assign bus.div_clk_en_o   = w_clk_en;
    assign bus.wb_valid_o     = w_wb_valid;
    assign bus.wb_result_o    = r_result;
    assign bus.wb_tag_o       = r_tag;
    assign bus.wb_rd_o        = r_rd;
    assign bus.wb_dz_o        = r_dz;

endmodule

// File: tb/tb_mgt_01_div_sequencer.sv
// tb/tb_mgt_01_div_sequencer.sv - directed bench for the divide sequencer with a divider model
module tb_mgt_01_div_sequencer;
    import MGT_01_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;

    int n_chk = 0;
    int n_err = 0;
    int lat_model = 34;
    int r_mcnt;

    mgt_01_div_sequencer_if bus ();

    mgt_01_div_sequencer dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // divider stand-in: counts enabled cycles, reports FREE once lat_model of them have elapsed
    always_ff @(posedge clk) begin
        if (!rst_n) r_mcnt <= 0;
        else if (bus.div_clk_en_o) r_mcnt <= r_mcnt + 1;
        else r_mcnt <= 0;
    end

    function automatic logic [31:0] model_div(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'd0;
        case (op)
            DIV_:    return $signed(a) / $signed(b);
            DIVU_:   return a / b;
            REM_:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    assign bus.div_state_i  = (r_mcnt >= lat_model - 1) ? FREE : BUSY;
    assign bus.div_result_i = model_div(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // called just after a rising edge; returns just after the accepting edge
    task automatic do_issue(input div_ops_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [4:0] rd, output logic acc);
        bus.issue_valid_i = 1'b1;
        bus.issue_op_i    = op;
        bus.issue_rs1_i   = a;
        bus.issue_rs2_i   = b;
        bus.issue_tag_i   = tag;
        bus.issue_rd_i    = rd;
        @(negedge clk);
        acc = bus.issue_ready_o;
        @(posedge clk); #1;
        bus.issue_valid_i = 1'b0;
    endtask

    // returns at the falling edge of the first wb_valid cycle; lat counts from the issue cycle
    task automatic wait_wb(output int lat, output logic saw_en);
        logic done;
        done   = 1'b0;
        lat    = 1;
        saw_en = 1'b0;
        while (!done) begin
            @(negedge clk);
            saw_en = saw_en | bus.div_clk_en_o;
            if (bus.wb_valid_o) begin
                done = 1'b1;
            end else if (lat >= 300) begin
                chk("wb_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic en;
        int   lat;
        int   cnt_v;
        int   cnt_e;

        rst_n = 1'b0;
        flush = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_op_i    = DIV_;
        bus.issue_rs1_i   = '0;
        bus.issue_rs2_i   = '0;
        bus.issue_tag_i   = '0;
        bus.issue_rd_i    = '0;
        bus.wb_ready_i    = 1'b1;

        // reset values
        @(negedge clk);
        chk("rst_issue_ready", bus.issue_ready_o, 1);
        chk("rst_wb_valid", bus.wb_valid_o, 0);
        chk("rst_clk_en", bus.div_clk_en_o, 0);
        chk("rst_dividend", bus.div_dividend_o, 0);
        chk("rst_divisor", bus.div_divisor_o, 0);
        chk("rst_wb_result", bus.wb_result_o, 0);
        chk("rst_wb_tag", bus.wb_tag_o, 0);
        chk("rst_wb_dz", bus.wb_dz_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // 1: DIV -20 / 2
        do_issue(DIV_, -32'sd20, 32'd2, 4'h3, 5'd7, acc);
        chk("t1_acc", acc, 1);
        wait_wb(lat, en);
        chk("t1_lat", lat, 35);
        chk("t1_en", en, 1);
        chk("t1_result", bus.wb_result_o, 32'hFFFF_FFF6);
        chk("t1_tag", bus.wb_tag_o, 4'h3);
        chk("t1_rd", bus.wb_rd_o, 5'd7);
        chk("t1_dz", bus.wb_dz_o, 0);
        step();

        // 2: REM -100 % -43, REMU 100 % 43
        do_issue(REM_, -32'sd100, -32'sd43, 4'h1, 5'd2, acc);
        wait_wb(lat, en);
        chk("t2_rem", bus.wb_result_o, 32'hFFFF_FFF2);
        step();
        do_issue(REMU_, 32'd100, 32'd43, 4'h2, 5'd3, acc);
        wait_wb(lat, en);
        chk("t2_remu", bus.wb_result_o, 32'd14);
        chk("t2_remu_lat", lat, 35);
        step();

        // 3: divide by zero
        do_issue(DIVU_, 32'd20, 32'd0, 4'h4, 5'd4, acc);
        wait_wb(lat, en);
        chk("t3_divu_lat", lat, 2);
        chk("t3_divu_en", en, 0);
        chk("t3_divu_res", bus.wb_result_o, 32'hFFFF_FFFF);
        chk("t3_divu_dz", bus.wb_dz_o, 1);
        step();
        do_issue(REM_, 32'd20, 32'd0, 4'h5, 5'd5, acc);
        wait_wb(lat, en);
        chk("t3_rem_res", bus.wb_result_o, 32'd20);
        chk("t3_rem_dz", bus.wb_dz_o, 1);
        step();

        // 4: signed overflow
        do_issue(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 4'h6, 5'd6, acc);
        wait_wb(lat, en);
        chk("t4_div_lat", lat, 2);
        chk("t4_div_res", bus.wb_result_o, 32'h8000_0000);
        chk("t4_div_dz", bus.wb_dz_o, 0);
        step();
        do_issue(REM_, 32'h8000_0000, 32'hFFFF_FFFF, 4'h7, 5'd8, acc);
        wait_wb(lat, en);
        chk("t4_rem_res", bus.wb_result_o, 32'd0);
        chk("t4_rem_dz", bus.wb_dz_o, 0);
        step();

        // divider still busy at the nominal sample point
        lat_model = 38;
        do_issue(DIV_, 32'd100, 32'd3, 4'h8, 5'd9, acc);
        wait_wb(lat, en);
        chk("busy_lat", lat, 39);
        chk("busy_res", bus.wb_result_o, 32'd33);
        step();
        lat_model = 34;

        // 5: writeback backpressure then back-to-back issue
        bus.wb_ready_i = 1'b0;
        do_issue(DIVU_, 32'd100, 32'd7, 4'h5, 5'd9, acc);
        wait_wb(lat, en);
        chk("t5_lat", lat, 35);
        step();
        bus.issue_valid_i = 1'b1;
        bus.issue_op_i    = DIV_;
        bus.issue_rs1_i   = 32'd7;
        bus.issue_rs2_i   = -32'sd2;
        bus.issue_tag_i   = 4'hA;
        bus.issue_rd_i    = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", bus.wb_valid_o, 1);
            chk("t5_hold_res", bus.wb_result_o, 32'd14);
            chk("t5_hold_tag", bus.wb_tag_o, 4'h5);
            chk("t5_hold_ready", bus.issue_ready_o, 0);
            chk("t5_hold_opnd", bus.div_dividend_o, 32'd100);
            step();
        end
        bus.wb_ready_i = 1'b1;
        @(negedge clk);
        chk("t5_rel_ready", bus.issue_ready_o, 1);
        chk("t5_rel_valid", bus.wb_valid_o, 1);
        step();
        bus.issue_valid_i = 1'b0;
        wait_wb(lat, en);
        chk("t5_b2b_lat", lat, 35);
        chk("t5_b2b_res", bus.wb_result_o, 32'hFFFF_FFFD);
        chk("t5_b2b_tag", bus.wb_tag_o, 4'hA);
        chk("t5_b2b_opnd", bus.div_dividend_o, 32'd7);
        step();

        // 6: flush mid-run with a simultaneous issue
        do_issue(DIV_, 32'd1000, 32'd10, 4'h9, 5'd1, acc);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (c == 9) chk("t6_run_en", bus.div_clk_en_o, 1);
            step();
        end
        flush = 1'b1;
        bus.issue_valid_i = 1'b1;
        bus.issue_op_i    = REM_;
        bus.issue_rs1_i   = 32'd55;
        bus.issue_rs2_i   = 32'd5;
        bus.issue_tag_i   = 4'hC;
        bus.issue_rd_i    = 5'd11;
        @(negedge clk);
        chk("t6_flush_ready", bus.issue_ready_o, 0);
        chk("t6_flush_en", bus.div_clk_en_o, 0);
        step();
        flush = 1'b0;
        bus.issue_valid_i = 1'b0;
        cnt_v = 0;
        cnt_e = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.wb_valid_o) cnt_v++;
            if (bus.div_clk_en_o) cnt_e++;
            step();
        end
        chk("t6_no_wb", cnt_v, 0);
        chk("t6_no_en", cnt_e, 0);
        chk("t6_not_acc", bus.div_dividend_o, 32'd1000);
        do_issue(REMU_, 32'd1000, 32'd7, 4'hD, 5'd12, acc);
        chk("t6_next_acc", acc, 1);
        wait_wb(lat, en);
        chk("t6_next_lat", lat, 35);
        chk("t6_next_res", bus.wb_result_o, 32'd6);
        chk("t6_next_tag", bus.wb_tag_o, 4'hD);
        step();

        // asynchronous reset mid-run
        do_issue(DIVU_, 32'd9, 32'd3, 4'hE, 5'd13, acc);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", bus.div_clk_en_o, 0);
        chk("arst_ready", bus.issue_ready_o, 1);
        chk("arst_opnd", bus.div_dividend_o, 0);
        step();
        rst_n = 1'b1;
        cnt_v = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wb_valid_o) cnt_v++;
            step();
        end
        chk("arst_no_wb", cnt_v, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
